// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD DAT-line write path.
// The serial CRC step is kept here so every line's CRC uses the same definition.
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_STATUS_WAIT,
    ST_STATUS,
    ST_BUSY
  } sdc_state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [2:0]  CRC_STATUS_OK = 3'b010;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_crc16_serial.sv
// Bit-serial CRC16 for one DAT line: accumulates data bits, then shifts the
// result out MSB first so the top only ever needs bit 15.
module sdc_crc16_serial
  import sdc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 16'h0000;
    end else if (shift) begin
      crc_d = {crc_q[14:0], 1'b0};
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdc_dat_serializer.sv
// SD DAT-line block transmitter: frames TX bytes with start bit, per-line CRC16
// and end bit, then collects the card's CRC-status token and waits out busy.
//
// state          | meaning
// ST_IDLE        | bus released, waiting for the first byte of a block
// ST_START       | start bit on active lines, byte 0 offered
// ST_DATA        | data slots, 8 per byte (1-bit) or 2 per byte (4-bit)
// ST_CRC         | 16 CRC bits per active line, MSB first
// ST_END         | end bit on active lines
// ST_STATUS_WAIT | bus released, waiting for token start bit on DAT0
// ST_STATUS      | 3 status bits then token end bit
// ST_BUSY        | card holds DAT0 low while programming
module sdc_dat_serializer
  import sdc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       wideBus,
  input  logic [3:0] sdDat_i,
  output logic [3:0] sdDat_o,
  output logic [3:0] oe,
  output logic       txWaiting,
  output logic       sdBusy,
  output logic       crcStatusErr,
  output logic       underflow
);

  sdc_state_e state_q, state_d;
  logic       wide_q, wide_d;
  logic       last_q, last_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sts_q, sts_d;
  logic [3:0] dat_q, dat_d;
  logic [3:0] oe_q, oe_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;
  logic       txw_q, txw_d;
  logic       err_q, err_d;
  logic       uf_q, uf_d;

  logic        crc_clr, crc_en, crc_shift;
  logic [3:0]  crc_din, crc_msb;
  logic [15:0] crc_w [4];

  logic [7:0] byte_in;
  logic [2:0] slot_end;
  logic [3:0] load_bits, next_bits, crc_bits;
  logic       unused_ok;

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sdc_crc16_serial u_crc (
      .clk   (clk),
      .rst   (rst),
      .clr   (crc_clr),
      .en    (crc_en & (wide_q | (i == 0))),
      .shift (crc_shift),
      .din   (crc_din[i]),
      .crc   (crc_w[i])
    );
    assign crc_msb[i] = crc_w[i][15];
  end

  // Only DAT0 carries the card's response; the low CRC bits leave through the shift.
  assign unused_ok = ^{sdDat_i[3:1], crc_w[0][14:0], crc_w[1][14:0],
                       crc_w[2][14:0], crc_w[3][14:0]};

  always_comb begin
    state_d    = state_q;
    wide_d     = wide_q;
    last_d     = last_q;
    sh_d       = sh_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    sts_d      = sts_q;
    dat_d      = dat_q;
    oe_d       = oe_q;
    in_ready_d = 1'b0;
    err_d      = 1'b0;
    uf_d       = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    crc_shift  = 1'b0;
    crc_din    = 4'h0;

    // A missing byte becomes an all-ones filler that is still CRC-covered.
    byte_in   = in_valid ? in_data : 8'hFF;
    slot_end  = wide_q ? 3'd1 : 3'd7;
    load_bits = wide_q ? byte_in[7:4] : {3'b111, byte_in[7]};
    next_bits = wide_q ? sh_q[7:4] : {3'b111, sh_q[7]};
    crc_bits  = wide_q ? crc_msb : {3'b111, crc_msb[0]};

    case (state_q)
      ST_IDLE: begin
        dat_d = 4'hF;
        oe_d  = 4'h0;
        if (in_valid) begin
          state_d    = ST_START;
          wide_d     = wideBus;
          dat_d      = wideBus ? 4'h0 : 4'hE;
          oe_d       = wideBus ? 4'hF : 4'h1;
          crc_clr    = 1'b1;
          in_ready_d = 1'b1;
        end
      end

      ST_START, ST_DATA: begin
        if (state_q == ST_START || (slot_q == slot_end && !last_q)) begin
          state_d = ST_DATA;
          slot_d  = 3'd0;
          uf_d    = !in_valid;
          last_d  = in_valid && in_last;
          sh_d    = wide_q ? {byte_in[3:0], 4'h0} : {byte_in[6:0], 1'b0};
          dat_d   = load_bits;
          crc_en  = 1'b1;
          crc_din = load_bits;
        end else if (slot_q == slot_end) begin
          state_d   = ST_CRC;
          cnt_d     = 4'd0;
          dat_d     = crc_bits;
          crc_shift = 1'b1;
        end else begin
          slot_d     = slot_q + 3'd1;
          sh_d       = wide_q ? {sh_q[3:0], 4'h0} : {sh_q[6:0], 1'b0};
          dat_d      = next_bits;
          crc_en     = 1'b1;
          crc_din    = next_bits;
          in_ready_d = (slot_d == slot_end) && !last_q;
        end
      end

      ST_CRC: begin
        if (cnt_q == 4'd15) begin
          state_d = ST_END;
          dat_d   = 4'hF;
        end else begin
          cnt_d     = cnt_q + 4'd1;
          dat_d     = crc_bits;
          crc_shift = 1'b1;
        end
      end

      ST_END: begin
        state_d = ST_STATUS_WAIT;
        oe_d    = 4'h0;
        dat_d   = 4'hF;
      end

      ST_STATUS_WAIT: begin
        if (!sdDat_i[0]) begin
          state_d = ST_STATUS;
          cnt_d   = 4'd0;
        end
      end

      ST_STATUS: begin
        cnt_d = cnt_q + 4'd1;
        sts_d = {sts_q[0], sdDat_i[0]};
        // Flag lands in the cycle the token end bit is on the wire.
        if (cnt_q == 4'd2) begin
          err_d = ({sts_q, sdDat_i[0]} != CRC_STATUS_OK);
        end
        if (cnt_q == 4'd3) begin
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (sdDat_i[0]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        oe_d    = 4'h0;
        dat_d   = 4'hF;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    txw_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wide_q     <= 1'b0;
      last_q     <= 1'b0;
      sh_q       <= 8'h00;
      slot_q     <= 3'd0;
      cnt_q      <= 4'd0;
      sts_q      <= 2'b00;
      dat_q      <= 4'hF;
      oe_q       <= 4'h0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      txw_q      <= 1'b1;
      err_q      <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wide_q     <= wide_d;
      last_q     <= last_d;
      sh_q       <= sh_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      sts_q      <= sts_d;
      dat_q      <= dat_d;
      oe_q       <= oe_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      txw_q      <= txw_d;
      err_q      <= err_d;
      uf_q       <= uf_d;
    end
  end

  assign sdDat_o      = dat_q;
  assign oe           = oe_q;
  assign in_ready     = in_ready_q;
  assign sdBusy       = busy_q;
  assign txWaiting    = txw_q;
  assign crcStatusErr = err_q;
  assign underflow    = uf_q;

endmodule
